// File: rtl/prog_launcher_pkg.sv
// Shared constants, state encoding and small helpers for the program launcher.
package prog_launcher_pkg;

    // Default batch / timing parameters.
    localparam int DEF_NUM_PROGS    = 3;
    localparam int DEF_CYCLE_W      = 16;
    localparam int DEF_TIMEOUT      = 16'hFFFF;
    localparam int DEF_RESET_CYCLES = 2;
    localparam int DEF_START_CYCLES = 2;

    // Program index width (supports up to four programs per batch).
    localparam int PROG_IDX_W = 2;

    // Launcher FSM state encoding.
    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_RST_DUT  = 3'd1;
    localparam state_t ST_START_HI = 3'd2;
    localparam state_t ST_RUN      = 3'd3;
    localparam state_t ST_REPORT   = 3'd4;
    localparam state_t ST_DONE     = 3'd5;

    // A batch is in progress in every state between Launch and DONE.
    function automatic logic is_busy(input state_t s);
        return (s == ST_RST_DUT) || (s == ST_START_HI) ||
               (s == ST_RUN)     || (s == ST_REPORT);
    endfunction

endpackage

// File: rtl/prog_launcher_sat.sv
// Saturating up-counter with synchronous clear and a terminal-count flag.
// Used for the reset/start phase timers and for the RUN cycle counter.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] max_val,
    output logic [WIDTH-1:0] count,
    output logic             at_max
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: clear wins, otherwise step up and stop at max_val.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q < max_val)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state flops use non-blocking assignment so all registers update together at the edge.
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count  = count_q;
    assign at_max = (count_q >= max_val);

endmodule

// File: rtl/prog_launcher.sv
// Start/Ack program launcher: resets the core, launches each program of a
// batch in turn, waits for its Ack and reports a per-program cycle count.
module prog_launcher
    import prog_launcher_pkg::*;
#(
    parameter int NUM_PROGS    = DEF_NUM_PROGS,
    parameter int CYCLE_W      = DEF_CYCLE_W,
    parameter int TIMEOUT      = DEF_TIMEOUT,
    parameter int RESET_CYCLES = DEF_RESET_CYCLES,
    parameter int START_CYCLES = DEF_START_CYCLES
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Launch,
    input  logic                  DutAck,
    output logic                  DutReset,
    output logic                  DutStart,
    output logic [PROG_IDX_W-1:0] ProgIdx,
    output logic [CYCLE_W-1:0]    CycleCount,
    output logic                  ResultValid,
    output logic                  TimedOut,
    output logic                  Busy,
    output logic                  Done
);

    localparam int PHASE_MAX = (RESET_CYCLES > START_CYCLES) ? RESET_CYCLES : START_CYCLES;
    localparam int PHASE_W   = $clog2(PHASE_MAX) + 1;

    state_t                state_q, state_d;
    logic [PROG_IDX_W-1:0] prog_idx_q, prog_idx_d;
    logic [CYCLE_W-1:0]    cycle_count_q, cycle_count_d;
    logic                  timed_out_q, timed_out_d;
    logic                  arm_q, arm_d;
    logic                  dut_reset_q, dut_reset_d;
    logic                  dut_start_q, dut_start_d;
    logic                  result_valid_q, result_valid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [PHASE_W-1:0]    phase_max;
    logic [PHASE_W-1:0]    phase_cnt_unused;
    logic                  phase_tc;
    logic [CYCLE_W-1:0]    run_cnt;
    logic                  run_at_max;
    logic                  ack_accept;

    // Phase timer limit follows the phase being timed.
    always_comb begin
        phase_max = (state_q == ST_RST_DUT) ? PHASE_W'(RESET_CYCLES - 1)
                                            : PHASE_W'(START_CYCLES - 1);
    end

    // Times the RST_DUT and START_HI phases; restarts on every state change.
    sat_counter #(.WIDTH(PHASE_W)) u_phase_timer (
        .clk     (Clk),
        .rst     (Reset),
        .clear   (state_d != state_q),
        .enable  (1'b1),
        .max_val (phase_max),
        .count   (phase_cnt_unused),
        .at_max  (phase_tc)
    );

    // Counts RUN cycles without an accepted Ack; zero on the first RUN cycle.
    sat_counter #(.WIDTH(CYCLE_W)) u_run_counter (
        .clk     (Clk),
        .rst     (Reset),
        .clear   (state_q != ST_RUN),
        .enable  ((state_q == ST_RUN) && !ack_accept),
        .max_val (CYCLE_W'(TIMEOUT)),
        .count   (run_cnt),
        .at_max  (run_at_max)
    );

    // Ack only counts once it has been seen low since this program's Start.
    assign ack_accept = (state_q == ST_RUN) && DutAck && arm_q;

    // Batch sequencing, result capture and the Ack arming flag.
    always_comb begin
        state_d       = state_q;
        prog_idx_d    = prog_idx_q;
        cycle_count_d = cycle_count_q;
        timed_out_d   = timed_out_q;
        arm_d         = arm_q;

        if (((state_q == ST_START_HI) || (state_q == ST_RUN)) && !DutAck) begin
            arm_d = 1'b1;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (Launch) begin
                    state_d       = ST_RST_DUT;
                    prog_idx_d    = '0;
                    cycle_count_d = '0;
                    timed_out_d   = 1'b0;
                end
            end
            ST_RST_DUT: begin
                if (phase_tc) state_d = ST_START_HI;
            end
            ST_START_HI: begin
                if (phase_tc) state_d = ST_RUN;
            end
            ST_RUN: begin
                // An Ack on the terminal cycle still counts as a completion.
                if (ack_accept) begin
                    state_d       = ST_REPORT;
                    cycle_count_d = run_cnt;
                    timed_out_d   = 1'b0;
                end else if (run_at_max) begin
                    state_d       = ST_REPORT;
                    cycle_count_d = CYCLE_W'(TIMEOUT);
                    timed_out_d   = 1'b1;
                end
            end
            ST_REPORT: begin
                if (timed_out_q || (prog_idx_q == PROG_IDX_W'(NUM_PROGS - 1))) begin
                    state_d = ST_DONE;
                end else begin
                    state_d    = ST_START_HI;
                    prog_idx_d = prog_idx_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A fresh Start phase must see Ack low again before accepting it.
        if ((state_d == ST_START_HI) && (state_q != ST_START_HI)) begin
            arm_d = 1'b0;
        end
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        dut_reset_d    = (state_d == ST_IDLE) || (state_d == ST_RST_DUT);
        dut_start_d    = (state_d == ST_START_HI);
        result_valid_d = (state_d == ST_REPORT);
        busy_d         = is_busy(state_d);
        done_d         = (state_d == ST_DONE);
    end

    // Launcher state and registered outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q        <= ST_IDLE;
            prog_idx_q     <= '0;
            cycle_count_q  <= '0;
            timed_out_q    <= 1'b0;
            arm_q          <= 1'b0;
            dut_reset_q    <= 1'b1;
            dut_start_q    <= 1'b0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            prog_idx_q     <= prog_idx_d;
            cycle_count_q  <= cycle_count_d;
            timed_out_q    <= timed_out_d;
            arm_q          <= arm_d;
            dut_reset_q    <= dut_reset_d;
            dut_start_q    <= dut_start_d;
            result_valid_q <= result_valid_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    assign DutReset    = dut_reset_q;
    assign DutStart    = dut_start_q;
    assign ProgIdx     = prog_idx_q;
    assign CycleCount  = cycle_count_q;
    assign ResultValid = result_valid_q;
    assign TimedOut    = timed_out_q;
    assign Busy        = busy_q;
    assign Done        = done_q;

endmodule

// File: tb/tb_prog_launcher.sv
// Directed bench for prog_launcher: normal batches, Ack arming, ignored
// Launch, async reset mid-batch, timeout and Ack-at-timeout.
module tb_prog_launcher;

    localparam int CW = 16;

    logic          Clk = 1'b0;
    logic          Reset, Launch, DutAck;
    logic          DutReset, DutStart, ResultValid, TimedOut, Busy, Done;
    logic [1:0]    ProgIdx;
    logic [CW-1:0] CycleCount;

    logic          Launch_b, DutAck_b;
    logic          DutReset_b, DutStart_b, ResultValid_b, TimedOut_b, Busy_b, Done_b;
    logic [1:0]    ProgIdx_b;
    logic [CW-1:0] CycleCount_b;

    int checks = 0;
    int errors = 0;

    prog_launcher #(
        .NUM_PROGS(3), .CYCLE_W(CW), .TIMEOUT(20), .RESET_CYCLES(2), .START_CYCLES(2)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Launch(Launch), .DutAck(DutAck),
        .DutReset(DutReset), .DutStart(DutStart), .ProgIdx(ProgIdx),
        .CycleCount(CycleCount), .ResultValid(ResultValid), .TimedOut(TimedOut),
        .Busy(Busy), .Done(Done)
    );

    prog_launcher #(
        .NUM_PROGS(3), .CYCLE_W(CW), .TIMEOUT(10), .RESET_CYCLES(2), .START_CYCLES(2)
    ) dut_b (
        .Clk(Clk), .Reset(Reset), .Launch(Launch_b), .DutAck(DutAck_b),
        .DutReset(DutReset_b), .DutStart(DutStart_b), .ProgIdx(ProgIdx_b),
        .CycleCount(CycleCount_b), .ResultValid(ResultValid_b), .TimedOut(TimedOut_b),
        .Busy(Busy_b), .Done(Done_b)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(negedge Clk);
    endtask

    // Pulse Launch; expect exactly two cycles of DutReset with Busy set.
    task automatic launch_batch();
        Launch = 1'b1;
        tick();
        Launch = 1'b0;
        check("launch_dutreset", DutReset, 1);
        check("launch_busy", Busy, 1);
        check("launch_done_clr", Done, 0);
        check("launch_progidx", ProgIdx, 0);
        check("launch_cycles_clr", CycleCount, 0);
        check("launch_to_clr", TimedOut, 0);
        check("launch_start", DutStart, 0);
        tick();
        check("rst_dut_cycle2", DutReset, 1);
    endtask

    task automatic start_phase(input int p);
        tick();
        check("start1_dutreset", DutReset, 0);
        check("start1_dutstart", DutStart, 1);
        check("start1_progidx", ProgIdx, p);
        check("start1_valid", ResultValid, 0);
        tick();
        check("start2_dutstart", DutStart, 1);
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check("run_dutstart", DutStart, 0);
            check("run_valid", ResultValid, 0);
            check("run_busy", Busy, 1);
        end
    endtask

    task automatic expect_report(input int p, input int cnt, input logic to);
        tick();
        check("rep_valid", ResultValid, 1);
        check("rep_progidx", ProgIdx, p);
        check("rep_cycles", CycleCount, cnt);
        check("rep_timedout", TimedOut, to);
        check("rep_busy", Busy, 1);
    endtask

    task automatic expect_done(input int p, input int cnt, input logic to);
        tick();
        check("done_flag", Done, 1);
        check("done_busy", Busy, 0);
        check("done_dutreset", DutReset, 0);
        check("done_dutstart", DutStart, 0);
        check("done_valid", ResultValid, 0);
        check("done_progidx", ProgIdx, p);
        check("done_cycles", CycleCount, cnt);
        check("done_timedout", TimedOut, to);
    endtask

    initial begin
        Reset    = 1'b1;
        Launch   = 1'b0;
        DutAck   = 1'b0;
        Launch_b = 1'b0;
        DutAck_b = 1'b0;
        repeat (2) tick();

        // Reset values.
        check("rst_dutreset", DutReset, 1);
        check("rst_dutstart", DutStart, 0);
        check("rst_progidx", ProgIdx, 0);
        check("rst_cycles", CycleCount, 0);
        check("rst_valid", ResultValid, 0);
        check("rst_timedout", TimedOut, 0);
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        Reset = 1'b0;
        tick();
        check("idle_dutreset", DutReset, 1);
        check("idle_busy", Busy, 0);

        // Batch 1: Ack on 5th RUN cycle of every program -> count 4.
        launch_batch();
        start_phase(0);
        run_cycles(5);
        DutAck = 1'b1;
        expect_report(0, 4, 1'b0);
        DutAck = 1'b0;

        // Program 1 with Launch pulsed during RUN and during REPORT.
        start_phase(1);
        run_cycles(2);
        Launch = 1'b1;
        run_cycles(1);
        Launch = 1'b0;
        run_cycles(2);
        DutAck = 1'b1;
        expect_report(1, 4, 1'b0);
        Launch = 1'b1;
        DutAck = 1'b0;
        tick();
        Launch = 1'b0;
        check("ign_launch_dutreset", DutReset, 0);
        check("ign_launch_dutstart", DutStart, 1);
        check("ign_launch_progidx", ProgIdx, 2);
        tick();
        check("ign_launch_start2", DutStart, 1);
        run_cycles(5);
        DutAck = 1'b1;
        expect_report(2, 4, 1'b0);
        DutAck = 1'b0;
        expect_done(2, 4, 1'b0);
        tick();
        check("done_sticky", Done, 1);

        // Batch 2 (Launch from DONE): Ack stuck high into program 1.
        launch_batch();
        start_phase(0);
        run_cycles(5);
        DutAck = 1'b1;
        expect_report(0, 4, 1'b0);
        start_phase(1);
        run_cycles(2);
        DutAck = 1'b0;
        run_cycles(2);
        DutAck = 1'b1;
        expect_report(1, 3, 1'b0);
        DutAck = 1'b0;
        start_phase(2);
        run_cycles(5);
        DutAck = 1'b1;
        expect_report(2, 4, 1'b0);
        DutAck = 1'b0;
        expect_done(2, 4, 1'b0);

        // Batch 3: async reset in the middle of program 1's RUN.
        launch_batch();
        start_phase(0);
        run_cycles(5);
        DutAck = 1'b1;
        expect_report(0, 4, 1'b0);
        DutAck = 1'b0;
        start_phase(1);
        run_cycles(3);
        #2 Reset = 1'b1;
        #1;
        check("async_dutreset", DutReset, 1);
        check("async_busy", Busy, 0);
        check("async_dutstart", DutStart, 0);
        check("async_progidx", ProgIdx, 0);
        check("async_cycles", CycleCount, 0);
        check("async_valid", ResultValid, 0);
        DutAck = 1'b1;
        tick();
        check("inrst_valid", ResultValid, 0);
        check("inrst_busy", Busy, 0);
        Reset = 1'b0;
        tick();
        check("postrst_valid", ResultValid, 0);
        check("postrst_busy", Busy, 0);
        check("postrst_dutreset", DutReset, 1);
        DutAck = 1'b0;

        // Batch 4: Ack never rises, TIMEOUT=20.
        launch_batch();
        start_phase(0);
        run_cycles(21);
        expect_report(0, 20, 1'b1);
        expect_done(0, 20, 1'b1);

        // Second instance, TIMEOUT=10: Ack on the cycle the counter hits 10.
        Launch_b = 1'b1;
        tick();
        Launch_b = 1'b0;
        check("b_launch_dutreset", DutReset_b, 1);
        check("b_launch_busy", Busy_b, 1);
        tick();
        tick();
        check("b_start_dutstart", DutStart_b, 1);
        tick();
        for (int i = 0; i < 11; i++) begin
            tick();
            check("b_run_valid", ResultValid_b, 0);
        end
        DutAck_b = 1'b1;
        tick();
        check("b_rep_valid", ResultValid_b, 1);
        check("b_rep_cycles", CycleCount_b, 10);
        check("b_rep_timedout", TimedOut_b, 0);
        check("b_rep_progidx", ProgIdx_b, 0);
        DutAck_b = 1'b0;
        tick();
        check("b_next_dutstart", DutStart_b, 1);
        check("b_next_progidx", ProgIdx_b, 1);
        check("b_next_busy", Busy_b, 1);
        check("b_next_done", Done_b, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
